// File: rtl/test_probe_pkg.sv
// Shared limits and filter counter type for the test_probe input conditioner.
package test_probe_pkg;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;
    localparam int FILTER_LEN_MIN  = 1;
    localparam int FILTER_LEN_MAX  = 255;
    localparam int CNT_W_MIN       = 1;
    localparam int CNT_W_MAX       = 32;
    localparam int FC_W            = 8;

    typedef logic [FC_W-1:0] fc_t;

    // Terminal filter count: the cycle on which a pending change is accepted.
    function automatic fc_t fc_last(input int filter_len);
        return fc_t'(filter_len - 1);
    endfunction

endpackage

// File: rtl/test_probe_sync.sv
// N-stage flip-flop synchronizer with synchronous active-high reset to 0.
module test_probe_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d};
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/test_probe.sv
// Input conditioner: synchronize, reject short glitches, emit edge strobes and
// a saturating transition counter.
module test_probe
    import test_probe_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             clear_count,
    output logic             out,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] change_count
);

    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : gen_bad_sync
        $error("test_probe: SYNC_STAGES out of range");
    end
    if (FILTER_LEN < FILTER_LEN_MIN || FILTER_LEN > FILTER_LEN_MAX) begin : gen_bad_filter
        $error("test_probe: FILTER_LEN out of range");
    end
    if (CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : gen_bad_cnt
        $error("test_probe: CNT_W out of range");
    end

    localparam fc_t             FcLast = fc_last(FILTER_LEN);
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic s;
    logic pending;
    logic accept;
    fc_t  fc_q;
    fc_t  fc_d;

    test_probe_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (in),
        .q   (s)
    );

    // Any cycle where s matches out restarts the window, discarding a pending change.
    always_comb begin
        pending = (s != out);
        accept  = pending && (fc_q == FcLast);
        fc_d    = (!pending || accept) ? '0 : fc_q + fc_t'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fc_q         <= '0;
            out          <= 1'b0;
            rise         <= 1'b0;
            fall         <= 1'b0;
            change_count <= '0;
        end else begin
            fc_q <= fc_d;
            rise <= accept & s;
            fall <= accept & ~s;
            if (accept) begin
                out <= s;
            end
            // Clear takes priority over a coincident transition.
            if (clear_count) begin
                change_count <= '0;
            end else if (accept && change_count != CntMax) begin
                change_count <= change_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_test_probe.sv
// Scoreboard bench for test_probe: default instance plus a 2-bit counter instance.
module tb_test_probe;

    localparam int SYNC = 2;
    localparam int FLEN = 4;

    logic        clk = 1'b0;
    logic        rst_v = 1'b1;
    logic        in_v = 1'b0;
    logic        clr_v = 1'b0;
    logic        dut_out, dut_rise, dut_fall;
    logic [15:0] dut_cnt;
    logic        sat_out, sat_rise, sat_fall;
    logic [1:0]  sat_cnt;

    always #5 clk = ~clk;

    test_probe #(
        .SYNC_STAGES (SYNC),
        .FILTER_LEN  (FLEN),
        .CNT_W       (16)
    ) dut (
        .clk          (clk),
        .rst          (rst_v),
        .in           (in_v),
        .clear_count  (clr_v),
        .out          (dut_out),
        .rise         (dut_rise),
        .fall         (dut_fall),
        .change_count (dut_cnt)
    );

    test_probe #(
        .SYNC_STAGES (SYNC),
        .FILTER_LEN  (FLEN),
        .CNT_W       (2)
    ) dut_sat (
        .clk          (clk),
        .rst          (rst_v),
        .in           (in_v),
        .clear_count  (clr_v),
        .out          (sat_out),
        .rise         (sat_rise),
        .fall         (sat_fall),
        .change_count (sat_cnt)
    );

    typedef struct {
        logic        out;
        logic        rise;
        logic        fall;
        logic [15:0] cnt;
        logic [1:0]  cnt_sat;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    logic [SYNC-1:0] m_sync = '0;
    int              m_fc = 0;
    logic            m_out = 0, m_rise = 0, m_fall = 0;
    logic [15:0]     m_cnt = '0;
    logic [1:0]      m_cnt_sat = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic i, input logic c, input logic r);
        logic s, acc;
        s = m_sync[SYNC-1];
        if (r) begin
            m_sync = '0; m_fc = 0; m_out = 0; m_rise = 0; m_fall = 0;
            m_cnt = '0; m_cnt_sat = '0;
        end else begin
            acc    = (s != m_out) && (m_fc == FLEN - 1);
            m_sync = {m_sync[SYNC-2:0], i};
            m_rise = acc && s;
            m_fall = acc && !s;
            if (s == m_out || acc) m_fc = 0;
            else m_fc++;
            if (acc) m_out = s;
            if (c) begin
                m_cnt = '0; m_cnt_sat = '0;
            end else if (acc) begin
                if (m_cnt != 16'hffff) m_cnt++;
                if (m_cnt_sat != 2'd3) m_cnt_sat++;
            end
        end
    endtask

    // Drive one cycle of inputs, push the expected post-edge outputs, then sample.
    task automatic step(input logic i, input logic c, input logic r);
        exp_t e;
        in_v = i; clr_v = c; rst_v = r;
        model_edge(i, c, r);
        e.out = m_out; e.rise = m_rise; e.fall = m_fall; e.cnt = m_cnt; e.cnt_sat = m_cnt_sat;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            e = sb_q.pop_front();
            check("out", dut_out, e.out);
            check("rise", dut_rise, e.rise);
            check("fall", dut_fall, e.fall);
            check("count", dut_cnt, e.cnt);
            check("sat_count", sat_cnt, e.cnt_sat);
            check("sat_out", sat_out, e.out);
            check("strobe_excl", dut_rise & dut_fall, 0);
        end
    endtask

    initial begin
        int rise1, rise2, fall1, high_cycles, lat;
        bit glitch_rise;

        // Reset held with in=1: everything must stay 0.
        for (int n = 0; n < 3; n++) step(1, 0, 1);
        check("rst_out", dut_out, 0);
        check("rst_count", dut_cnt, 0);
        for (int n = 0; n < 10; n++) step(0, 0, 0);

        // Level follow; latency counts edges starting with the first edge that sees the new level.
        rise1 = -1; rise2 = -1; fall1 = -1;
        for (int n = 0; n < 40; n++) begin
            step((n >= 10 && n < 20) || n >= 30, 0, 0);
            if (dut_rise) begin
                if (rise1 < 0) rise1 = n;
                else rise2 = n;
            end
            if (dut_fall) fall1 = n;
        end
        check("lat_rise1", rise1 - 10 + 1, 6);
        check("lat_fall", fall1 - 20 + 1, 6);
        check("lat_rise2", rise2 - 30 + 1, 6);
        check("follow_count", dut_cnt, 3);

        for (int n = 0; n < 10; n++) step(0, 0, 0);
        check("pre_glitch_count", dut_cnt, 4);

        // 3-cycle pulse must be rejected.
        glitch_rise = 0;
        for (int n = 0; n < 13; n++) begin
            step(n < 3, 0, 0);
            if (dut_rise || dut_out) glitch_rise = 1;
        end
        check("glitch_rejected", glitch_rise, 0);
        check("glitch_count", dut_cnt, 4);

        // 4-cycle pulse is the minimum accepted width.
        high_cycles = 0;
        for (int n = 0; n < 16; n++) begin
            step(n < 4, 0, 0);
            if (dut_out) high_cycles++;
        end
        check("min_pulse_high", high_cycles, 4);
        check("min_pulse_count", dut_cnt, 6);
        check("sat_hold", sat_cnt, 3);

        // Clear on the accepting edge: strobe still fires, count goes to 0.
        for (int n = 0; n < 5; n++) step(1, 0, 0);
        step(1, 1, 0);
        check("clr_rise", dut_rise, 1);
        check("clr_count", dut_cnt, 0);
        step(1, 0, 0);
        check("clr_hold", dut_cnt, 0);

        // Reset two cycles into a pending rise.
        for (int n = 0; n < 10; n++) step(0, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 1);
        check("midrst_out", dut_out, 0);
        lat = -1;
        for (int n = 0; n < 20; n++) begin
            step(1, 0, 0);
            if (dut_rise && lat < 0) lat = n + 1;
        end
        check("midrst_lat", lat, 6);
        check("midrst_count", dut_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/test_probe.md
# test_probe

Single-bit input conditioner: synchronizes the asynchronous `in` to `clk`, rejects glitches shorter than a programmable window, and drives the cleaned level on `out`. It also produces one-cycle rise/fall strobes and a saturating transition counter for status and debug. It sits at the boundary between an external or unsynchronized signal and the synchronous core logic.

## Interface
- `SYNC_STAGES`, 2: flip-flops in the synchronizer chain; legal range 2..4.
- `FILTER_LEN`, 4: consecutive cycles the synchronized value must differ from `out` before `out` follows; legal range 1..255.
- `CNT_W`, 16: width of `change_count`; legal range 1..32.
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst`  input  1  one clock; reset is synchronous and active-high.
- `in`  input  1  raw, possibly asynchronous level.
- `clear_count`  input  1  synchronous clear of `change_count`, sampled each rising edge.
- `out`  output  1  filtered, synchronized level.
- `rise`  output  1  one-cycle strobe in the cycle `out` goes 0→1.
- `fall`  output  1  one-cycle strobe in the cycle `out` goes 1→0.
- `change_count`  output  CNT_W  number of `out` transitions since reset/clear, saturating.

## Operation
- Reset (`rst`=1 at a rising edge): synchronizer stages, filter counter, `out`, `rise`, `fall`, `change_count` all 0.
- Synchronizer: `in` shifts through `SYNC_STAGES` registers; last stage is `s`.
- Filter: counter `fc` (8 bits).
  - `s` == `out`: `fc` ← 0.
  - `s` != `out` and `fc` < `FILTER_LEN`-1: `fc` ← `fc`+1.
  - `s` != `out` and `fc` == `FILTER_LEN`-1: `out` ← `s`, `fc` ← 0.
- Any return of `s` to `out` before acceptance discards the pending change (glitch rejected).
- `rise`/`fall`: registered alongside `out`; asserted high exactly in the cycle `out` holds its new value, low otherwise. Never both high.
- `change_count`: +1 on each `out` transition; holds at 2^CNT_W−1.
- `clear_count` and a transition in the same cycle: clear wins, `change_count` ← 0.
- `rst` mid-filter: pending change discarded; `out` returns to 0 regardless of `in`; if `in`=1 after reset, `out` rises after the full latency.

## Timing
- Latency, `in` change (stable before edge k) to `out` change: `SYNC_STAGES`+`FILTER_LEN` rising edges; default 6.
- Minimum accepted pulse width on `in`: `FILTER_LEN` cycles (in synchronized domain); shorter pulses never reach `out`.
- `rise`/`fall` width exactly 1 cycle; same edge as `out` update.
- `change_count` updates on the same edge as `out`; `clear_count` effective on the next edge.
- No combinational path from any input to any output.

## Structure
- Package `test_probe_pkg`: parameter limits (`SYNC_STAGES_MIN/MAX`, `FILTER_LEN_MAX`), filter counter width constant (8).
- Sub-module `test_probe_sync`: parameterized N-stage synchronizer with synchronous reset to 0; instantiated once.
- Top holds filter, edge strobes, counter, elaboration-time parameter range checks.

## Test plan
- Reset: hold `rst` 3 cycles with `in`=1 → `out`=0, `rise`=`fall`=0, `change_count`=0 throughout.
- Level follow (defaults): `in` 0→1 at cycle 10, →0 at 20, →1 at 30 → `out` rises at 16, falls at 26, rises at 36; `rise` pulses at 16 and 36, `fall` at 26; `change_count`=3.
- Glitch: `in`=1 for 3 cycles then 0 → `out` stays 0, no strobes, count unchanged; `in`=1 for 4 cycles → `out` high for 4 cycles, count +2.
- Saturation: `CNT_W`=2, 5 accepted transitions → `change_count` 1,2,3,3,3.
- Clear collision: assert `clear_count` in the cycle of an `out` transition → `change_count`=0 next cycle, `rise`/`fall` still pulse.
- Reset mid-operation: `rst` 2 cycles after `in` 0→1 → `out` stays 0; after release with `in`=1, `out` rises 6 cycles later.
